muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the MIPS pipeline (mult, div, mfhi, mflo).
//  Sits beside the EX stage: decode issues start/op, the unit runs 1 bit per cycle.
//  Raises stall to freeze the front of the pipeline while a mfhi/mflo/mult/div meets an in-flight op.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO are WIDTH bits each, product is 2*WIDTH
// PORTS
//  clk     in   1      single clock, all state on rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      decode holds mult/div this cycle
//  op      in   1      0 = mult, 1 = div (valid with start)
//  a       in   WIDTH  rs operand (multiplicand / dividend)
//  b       in   WIDTH  rt operand (multiplier / divisor)
//  rd_hi   in   1      decode holds mfhi
//  rd_lo   in   1      decode holds mflo
//  busy    out  1      operation in progress
//  done    out  1      one-cycle pulse, HI/LO updated on the same edge
//  stall   out  1      hold IF/ID and bubble EX
//  hi      out  WIDTH  HI register (mult upper half / div remainder)
//  lo      out  WIDTH  LO register (mult lower half / div quotient)
// BEHAVIOUR
//  Reset: busy=0, done=0, stall=0, hi=0, lo=0, FSM=IDLE, count=0. Reset mid-op aborts; HI/LO cleared.
//  FSM: IDLE --start--> MUL (op=0) or DIV (op=1); MUL/DIV --count==WIDTH-1--> IDLE.
//  Accept edge E0 (IDLE & start): latch a, b, op; count=0. busy=1 from E0+ on.
//  Iterations on edges E1..E_WIDTH, one bit each; count increments, no wrap past WIDTH-1.
//  On E_WIDTH: hi/lo written, FSM->IDLE, busy=0, done=1 for exactly one cycle. Latency = WIDTH cycles.
//  mult: 2*WIDTH-bit shift-add, {hi,lo}=a*b, no overflow flag.
//  div: restoring; lo=a/b, hi=a%b. b==0: lo=all-ones, hi=a (natural restoring result, no trap).
//  hi/lo hold their last value between ops; intermediate values never visible on hi/lo.
//  stall = busy & (start | rd_hi | rd_lo), combinational; 0 in the done cycle (HI/LO already valid).
//  start while busy: not accepted (stall holds it; re-presented). start in done cycle: accepted.
//  start with rd_hi/rd_lo simultaneously: impossible from decode; start has priority.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: a/b two's complement. Magnitudes taken at E0, signs latched;
//   product negated if sa^sb; quotient sign sa^sb, remainder sign sa. -2^(W-1)/-1: lo=0x80000000, hi=0.
//   b==0: lo=all-ones, hi=a. Latency unchanged (sign fix folded into final edge).
//  MULDIV_SIGNED_EN undefined: all operands unsigned; sign logic absent.
// STRUCTURE
//  mips_pkg: MD_OP_MULT/MD_OP_DIV constants, md_state_t enum {IDLE, MUL, DIV}, MD_WIDTH default.
//  Sub-module div_step: combinational one-bit restoring step (rem_in, divisor -> rem_out, q_bit).
//  FSM, counter, shift registers and HI/LO in this module.
// TESTING
//  mult 7*6 -> done at E32 exactly once, lo=42, hi=0, busy low after done.
//  mult 0xFFFFFFFF*0xFFFFFFFF (unsigned) -> hi=0xFFFFFFFE, lo=0x00000001.
//  div 100/7 -> lo=14, hi=2; div 5/0 -> lo=0xFFFFFFFF, hi=5.
//  rd_lo held from E3 -> stall=1 through E31 cycle, stall=0 in done cycle, lo new value.
//  rst at iteration 10 -> next cycle busy=0, done=0, hi=lo=0; fresh div 9/3 -> lo=3, hi=0.
//  MULDIV_SIGNED_EN: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; mult -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and state type for the MIPS multiply/divide unit.
package mips_pkg;

  localparam int   MD_WIDTH   = 32;
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One bit of a restoring divide. rem_in is the partial remainder already
// shifted left with the next dividend bit appended (WIDTH+1 bits). The
// divisor is subtracted when it fits; otherwise the shifted value is kept.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] diff;

  // When the divisor fits, the true difference is below 2^WIDTH, so the low
  // WIDTH bits of a modulo-2^WIDTH subtraction are exact.
  assign q_bit   = (rem_in >= {1'b0, divisor});
  assign diff    = rem_in[WIDTH-1:0] - divisor;
  assign rem_out = q_bit ? diff : rem_in[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers (mult, div, mfhi, mflo).
// One result bit per cycle; WIDTH cycles from accept to done.
// Optional feature: define MULDIV_SIGNED_EN for two's complement operands
// (magnitudes are iterated, signs are applied on the final edge).
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // acc_q: mult = {partial upper, remaining multiplier bits};
  //        div  = {partial remainder, dividend bits / quotient bits}
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor

  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_rem_in;
  logic [WIDTH-1:0]   div_rem_out;
  logic               div_q;
  logic [2*WIDTH-1:0] div_next;

  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept = (state_q == IDLE) && start;
  assign last   = (count_q == CW'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  logic sa_q;
  logic sb_q;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  // Operand signs, captured with the magnitudes on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      sa_q <= a[WIDTH-1];
      sb_q <= b[WIDTH-1];
    end
  end
`else
  assign mag_a = a;
  assign mag_b = b;
`endif

  // Shift-add step: add multiplicand when the low multiplier bit is set, shift right
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: bring in the next dividend bit, shift quotient bit in at the bottom
  assign div_rem_in = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (div_rem_in),
    .divisor (opnd_q),
    .rem_out (div_rem_out),
    .q_bit   (div_q)
  );

  assign div_next = {div_rem_out, acc_q[WIDTH-2:0], div_q};
  assign acc_d    = (state_q == DIV) ? div_next : mul_next;

  // Final HI/LO value as it would look after this cycle's step
  always_comb begin
    res_hi = acc_d[2*WIDTH-1:WIDTH];
    res_lo = acc_d[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (state_q == MUL) begin
      if (sa_q ^ sb_q) {res_hi, res_lo} = -acc_d;
    end else begin
      // Divide by zero keeps the all-ones quotient; remainder still follows a's sign
      if ((sa_q ^ sb_q) && (opnd_q != '0)) res_lo = -acc_d[WIDTH-1:0];
      if (sa_q) res_hi = -acc_d[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Datapath shift registers: load on accept, step every busy cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      if (op == MD_OP_DIV) begin
        acc_q  <= {{WIDTH{1'b0}}, mag_a};
        opnd_q <= mag_b;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, mag_b};
        opnd_q <= mag_a;
      end
    end else if (state_q != IDLE) begin
      acc_q <= acc_d;
    end
  end

  // Control FSM with registered busy/done and the architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= (op == MD_OP_MULT) ? MUL : DIV;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        MUL, DIV: begin
          if (last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi;
            lo_q    <= res_lo;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  // busy is already low in the done cycle, so a dependent read proceeds there
  assign stall = busy_q & (start | rd_hi | rd_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH = 32), with a reference
// model built on native 64-bit arithmetic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd_hi (rd_hi),
    .rd_lo (rd_lo),
    .busy  (busy),
    .done  (done),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_SIGNED_EN
    longint sx, sy, q, r;
    sx = $signed(x);
    sy = $signed(y);
    if (!o) return 64'(sx * sy);
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
`else
    longint unsigned ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!o) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {32'(ux % uy), 32'(ux / uy)};
`endif
  endfunction

  // Issue one op, wait (bounded) for done. Returns latency (-1 on timeout),
  // cycles with busy low before done, cycles where hi/lo moved before done.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input bit at_neg, output int lat, output int busy_gaps,
                        output int hl_moves, output logic [31:0] h, output logic [31:0] l);
    logic [31:0] h0, l0;
    if (!at_neg) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    h0 = hi; l0 = lo;
    lat = -1; busy_gaps = 0; hl_moves = 0; h = '0; l = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c; h = hi; l = lo;
        break;
      end
      if (busy !== 1'b1) busy_gaps++;
      if (hi !== h0 || lo !== l0) hl_moves++;
    end
  endtask

  task automatic test_reset;
    start = 1'b1; rd_hi = 1'b1; rd_lo = 1'b1; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got %h want 0", lo); end
    start = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0; rst = 1'b0;
  endtask

  task automatic test_mult_basic;
    int lat, gaps, moves;
    logic [31:0] h, l;
    run_op(1'b0, 32'd7, 32'd6, 1'b0, lat, gaps, moves, h, l);
    checks++; if (lat !== 32) begin failures++; $display("FAIL mult7x6_latency got %0d want 32", lat); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL mult7x6_busy_gaps got %0d want 0", gaps); end
    checks++; if (moves !== 0) begin failures++; $display("FAIL mult7x6_hilo_early got %0d want 0", moves); end
    checks++; if (l !== 32'd42) begin failures++; $display("FAIL mult7x6_lo got %h want 0000002a", l); end
    checks++; if (h !== 32'd0) begin failures++; $display("FAIL mult7x6_hi got %h want 0", h); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult7x6_done_once got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult7x6_busy_after got %b want 0", busy); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL mult7x6_lo_hold got %h want 0000002a", lo); end
  endtask

  task automatic test_directed;
    int lat, gaps, moves;
    logic [31:0] h, l;
    logic [63:0] exp;
`ifndef MULDIV_SIGNED_EN
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, gaps, moves, h, l);
    checks++; if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL mult_max got %h_%h want fffffffe_00000001", h, l); end
`endif
    run_op(1'b1, 32'd100, 32'd7, 1'b0, lat, gaps, moves, h, l);
    checks++; if (lat !== 32) begin failures++; $display("FAIL div100_7_latency got %0d want 32", lat); end
    checks++; if (l !== 32'd14) begin failures++; $display("FAIL div100_7_lo got %h want 0000000e", l); end
    checks++; if (h !== 32'd2) begin failures++; $display("FAIL div100_7_hi got %h want 00000002", h); end
    run_op(1'b1, 32'd5, 32'd0, 1'b0, lat, gaps, moves, h, l);
    checks++; if (l !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div5_0_lo got %h want ffffffff", l); end
    checks++; if (h !== 32'd5) begin failures++; $display("FAIL div5_0_hi got %h want 00000005", h); end
`ifdef MULDIV_SIGNED_EN
    run_op(1'b1, -32'sd7, 32'sd2, 1'b0, lat, gaps, moves, h, l);
    checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL sdiv_m7_2 got %h_%h want ffffffff_fffffffd", h, l); end
    run_op(1'b0, -32'sd3, 32'sd4, 1'b0, lat, gaps, moves, h, l);
    checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFF4) begin failures++; $display("FAIL smul_m3_4 got %h_%h want ffffffff_fffffff4", h, l); end
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, gaps, moves, h, l);
    checks++; if ({h, l} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL sdiv_min_m1 got %h_%h want 00000000_80000000", h, l); end
    run_op(1'b1, -32'sd9, 32'd0, 1'b0, lat, gaps, moves, h, l);
    exp = model(1'b1, -32'sd9, 32'd0);
    checks++; if ({h, l} !== exp) begin failures++; $display("FAIL sdiv_neg_by0 got %h_%h want %h", h, l, exp); end
`endif
  endtask

  task automatic test_stall;
    logic [31:0] x, y;
    logic [63:0] exp;
    x = $urandom; y = $urandom;
    exp = model(1'b0, x, y);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 3) rd_lo = 1'b1;
      #1;
      if (c < 32) begin
        checks++;
        if (stall !== (c >= 3)) begin failures++; $display("FAIL stall_cycle%0d got %b want %b", c, stall, (c >= 3)); end
      end else begin
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_done_cycle got %b want 0", stall); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done_pulse got %b want 1", done); end
        checks++; if (lo !== exp[31:0]) begin failures++; $display("FAIL stall_lo got %h want %h", lo, exp[31:0]); end
      end
    end
    rd_lo = 1'b0;
  endtask

  task automatic test_start_while_busy;
    logic [31:0] x, y, h, l;
    logic [63:0] exp;
    int lat;
    x = $urandom; y = $urandom_range(1, 1000);
    exp = model(1'b1, x, y);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; h = '0; l = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin lat = c; h = hi; l = lo; break; end
      if (c >= 5 && c <= 7) begin
        start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL busy_start_stall c%0d got %b want 1", c, stall); end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++; if (lat !== 32) begin failures++; $display("FAIL busy_start_latency got %0d want 32", lat); end
    checks++; if ({h, l} !== exp) begin failures++; $display("FAIL busy_start_result got %h_%h want %h", h, l, exp); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_ghost got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, gaps, moves;
    logic [31:0] h, l, x, y;
    logic [63:0] exp;
    run_op(1'b0, 32'd1234, 32'd5678, 1'b0, lat, gaps, moves, h, l);
    checks++; if ({h, l} !== model(1'b0, 32'd1234, 32'd5678)) begin failures++; $display("FAIL b2b_first got %h_%h want %h", h, l, model(1'b0, 32'd1234, 32'd5678)); end
    x = $urandom; y = $urandom_range(1, 50);
    exp = model(1'b1, x, y);
    run_op(1'b1, x, y, 1'b1, lat, gaps, moves, h, l);
    checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got %0d want 32", lat); end
    checks++; if (gaps !== 0) begin failures++; $display("FAIL b2b_busy_gaps got %0d want 0", gaps); end
    checks++; if ({h, l} !== exp) begin failures++; $display("FAIL b2b_second got %h_%h want %h", h, l, exp); end
  endtask

  task automatic test_reset_mid;
    int lat, gaps, moves;
    logic [31:0] h, l;
    run_op(1'b1, 32'd100, 32'd7, 1'b0, lat, gaps, moves, h, l);
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = $urandom; b = $urandom_range(1, 99);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstmid_lo got %h want 0", lo); end
    run_op(1'b1, 32'd9, 32'd3, 1'b0, lat, gaps, moves, h, l);
    checks++; if (lat !== 32) begin failures++; $display("FAIL rstmid_div9_3_latency got %0d want 32", lat); end
    checks++; if (l !== 32'd3) begin failures++; $display("FAIL rstmid_div9_3_lo got %h want 00000003", l); end
    checks++; if (h !== 32'd0) begin failures++; $display("FAIL rstmid_div9_3_hi got %h want 0", h); end
  endtask

  task automatic test_random;
    int lat, gaps, moves;
    logic [31:0] h, l, x, y;
    logic o;
    logic [63:0] exp;
    for (int n = 0; n < 30; n++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = {16'd0, 16'($urandom)};
        default: y = $urandom;
      endcase
      exp = model(o, x, y);
      run_op(o, x, y, 1'b0, lat, gaps, moves, h, l);
      checks++;
      if (lat !== 32 || gaps !== 0 || moves !== 0 || {h, l} !== exp) begin
        failures++;
        $display("FAIL random%0d op=%b a=%h b=%h got lat=%0d gaps=%0d moves=%0d %h_%h want lat=32 %h",
                 n, o, x, y, lat, gaps, moves, h, l, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult_basic();
    test_directed();
    test_stall();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
